seq_alu: RTL and testbench

- Parametrised accumulator ALU with an encoded opcode interface and a valid/ready handshake.
- Multiply and divide run as signed, iterative multi-cycle operations; all other ops complete in one cycle.
- Sits between the control unit (opcode issue) and the datapath (BR load, ACC/HI readout).
- Replaces one-hot control bits and combinational `*`, `/`, `%` with a deterministic-latency engine.

---
 rtl/seq_alu_pkg.sv | 41 ++++
 rtl/seq_muldiv_core.sv | 71 +++++++
 rtl/seq_alu.sv | 199 +++++++++++++++++++
 tb/tb_seq_alu.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the seq_alu accumulator engine.
// Opcode and FSM state encodings plus the signed-limit helpers used by the saturating build.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_CLR  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SAL  = 4'd8,
    OP_SAR  = 4'd9,
    OP_AND  = 4'd10,
    OP_OR   = 4'd11,
    OP_NOT  = 4'd12,
    OP_XOR  = 4'd13,
    OP_XNOR = 4'd14,
    OP_RSV  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 64;

  // Two's complement limits for a given data width, zero-extended to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply (mode=0) or restoring divide (mode=1),
// one bit per cycle for WIDTH cycles after start. Operands are magnitudes; signs live outside.
module seq_muldiv_core #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  logic [CNT_W-1:0] cnt_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // hi_reg is the partial product / remainder, lo_reg the multiplier / quotient-in-progress.
  always_comb begin
    add_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      mode_reg <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      b_reg    <= '0;
    end else if (start) begin
      cnt_reg  <= CNT_W'(WIDTH);
      mode_reg <= mode;
      hi_reg   <= '0;
      lo_reg   <= a;
      b_reg    <= b;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (mode_reg) begin
        // Top bit of the difference is the borrow: clear means the divisor fits.
        if (!div_diff[WIDTH]) begin
          hi_reg <= div_diff[WIDTH-1:0];
          lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
        end else begin
          hi_reg <= div_shift[WIDTH-1:0];
          lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
        end
      end else begin
        {hi_reg, lo_reg} <= {add_sum, lo_reg[WIDTH-1:1]};
      end
    end
  end

  assign busy      = (cnt_reg != '0);
  assign last      = (cnt_reg == CNT_W'(1));
  assign result_hi = hi_reg;
  assign result_lo = lo_reg;

endmodule

// File: rtl/seq_alu.sv
// Accumulator ALU with valid/ready opcode issue and a signed iterative MUL/DIV engine.
// Build option SEQ_ALU_SATURATE_EN: ADD/SUB saturate to the signed limits instead of wrapping.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] br_in,
  input  logic             br_load,
  input  logic             op_valid,
  input  logic [3:0]       op_code,
  output logic             op_ready,
  output logic             done,
  output logic             div_by_zero,
  output logic             flag,
  output logic [WIDTH-1:0] high_output,
  output logic [WIDTH-1:0] low_output
);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] br_reg, br_next;
  logic             dbz_reg, dbz_next;
  logic             done_reg, done_next;
  logic             mul_reg, mul_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;

  op_e              op;
  logic             accept;
  logic [WIDTH-1:0] acc_mag, br_mag;
  logic [WIDTH-1:0] sum_wrap, diff_wrap;
  logic [WIDTH-1:0] add_res, sub_res;

  logic             core_start, core_mode;
  logic             core_busy, core_last;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op       = op_e'(op_code);
  assign op_ready = (state_reg == IDLE) && !core_busy;
  assign accept   = op_valid && op_ready;

  assign acc_mag   = acc_reg[WIDTH-1] ? -acc_reg : acc_reg;
  assign br_mag    = br_reg[WIDTH-1]  ? -br_reg  : br_reg;
  assign sum_wrap  = acc_reg + br_reg;
  assign diff_wrap = acc_reg - br_reg;

`ifdef SEQ_ALU_SATURATE_EN
  localparam logic [WIDTH-1:0] SIGNED_MAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SIGNED_MIN = WIDTH'(signed_min(WIDTH));

  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] sat_val;

  // Overflow can only push the result away from the accumulator's own sign.
  assign add_ovf = (acc_reg[WIDTH-1] == br_reg[WIDTH-1]) && (sum_wrap[WIDTH-1]  != acc_reg[WIDTH-1]);
  assign sub_ovf = (acc_reg[WIDTH-1] != br_reg[WIDTH-1]) && (diff_wrap[WIDTH-1] != acc_reg[WIDTH-1]);
  assign sat_val = acc_reg[WIDTH-1] ? SIGNED_MIN : SIGNED_MAX;
  assign add_res = add_ovf ? sat_val : sum_wrap;
  assign sub_res = sub_ovf ? sat_val : diff_wrap;
`else
  assign add_res = sum_wrap;
  assign sub_res = diff_wrap;
`endif

  seq_muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .mode      (core_mode),
    .a         (acc_mag),
    .b         (br_mag),
    .busy      (core_busy),
    .last      (core_last),
    .result_hi (core_hi),
    .result_lo (core_lo)
  );

  // Sign restoration applied in FIX; remainder takes the dividend's sign.
  assign prod_mag = {core_hi, core_lo};
  assign prod_fix = neg_q_reg ? -prod_mag : prod_mag;
  assign quo_fix  = neg_q_reg ? -core_lo : core_lo;
  assign rem_fix  = neg_r_reg ? -core_hi : core_hi;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    hi_next    = hi_reg;
    br_next    = br_reg;
    dbz_next   = dbz_reg;
    done_next  = 1'b0;
    mul_next   = mul_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    core_start = 1'b0;
    core_mode  = 1'b0;

    if (br_load) br_next = br_in;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          dbz_next  = 1'b0;
          done_next = 1'b1;
          case (op)
            OP_CLR:  acc_next = '0;
            OP_ADD:  acc_next = add_res;
            OP_SUB:  acc_next = sub_res;
            OP_MUL: begin
              core_start = 1'b1;
              done_next  = 1'b0;
              mul_next   = 1'b1;
              neg_q_next = acc_reg[WIDTH-1] ^ br_reg[WIDTH-1];
              state_next = RUN;
            end
            OP_DIV: begin
              if (br_reg == '0) begin
                acc_next = '1;
                hi_next  = acc_reg;
                dbz_next = 1'b1;
              end else begin
                core_start = 1'b1;
                core_mode  = 1'b1;
                done_next  = 1'b0;
                mul_next   = 1'b0;
                neg_q_next = acc_reg[WIDTH-1] ^ br_reg[WIDTH-1];
                neg_r_next = acc_reg[WIDTH-1];
                state_next = RUN;
              end
            end
            OP_SHL, OP_SAL: acc_next = {acc_reg[WIDTH-2:0], 1'b0};
            OP_SHR:  acc_next = {1'b0, acc_reg[WIDTH-1:1]};
            OP_SAR:  acc_next = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
            OP_AND:  acc_next = acc_reg & br_reg;
            OP_OR:   acc_next = acc_reg | br_reg;
            OP_NOT:  acc_next = ~acc_reg;
            OP_XOR:  acc_next = acc_reg ^ br_reg;
            OP_XNOR: acc_next = ~(acc_reg ^ br_reg);
            default: acc_next = acc_reg;
          endcase
        end
      end
      RUN: begin
        if (core_last) state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        done_next  = 1'b1;
        if (mul_reg) begin
          {hi_next, acc_next} = prod_fix;
        end else begin
          acc_next = quo_fix;
          hi_next  = rem_fix;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      hi_reg    <= '0;
      br_reg    <= '0;
      dbz_reg   <= 1'b0;
      done_reg  <= 1'b0;
      mul_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      hi_reg    <= hi_next;
      br_reg    <= br_next;
      dbz_reg   <= dbz_next;
      done_reg  <= done_next;
      mul_reg   <= mul_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
    end
  end

  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign flag        = acc_reg[WIDTH-1];
  assign high_output = hi_reg;
  assign low_output  = acc_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=16): directed scenarios with literal expectations plus a random
// phase, all checked every cycle against an arithmetic model of the accumulator.
module tb_seq_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] br_in = '0;
  logic         br_load = 1'b0;
  logic         op_valid = 1'b0;
  logic [3:0]   op_code = '0;
  logic         op_ready, done, div_by_zero, flag;
  logic [W-1:0] high_output, low_output;

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .br_in       (br_in),
    .br_load     (br_load),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_ready    (op_ready),
    .done        (done),
    .div_by_zero (div_by_zero),
    .flag        (flag),
    .high_output (high_output),
    .low_output  (low_output)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] m_acc = '0, m_hi = '0, m_br = '0, p_acc = '0, p_hi = '0;
  bit          m_dbz = 1'b0, m_done = 1'b0;
  int          m_busy = 0;

  function automatic logic [15:0] arith(input int s);
`ifdef SEQ_ALU_SATURATE_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return 16'(s);
  endfunction

  task automatic model_edge();
    logic [15:0] old_br;
    int a, b;
    longint p;
    if (rst) begin
      m_acc = '0; m_hi = '0; m_br = '0; m_dbz = 0; m_done = 0; m_busy = 0;
      return;
    end
    m_done = 0;
    old_br = m_br;
    if (br_load) m_br = br_in;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_acc = p_acc; m_hi = p_hi; m_done = 1;
      end
    end else if (op_valid) begin
      a = $signed(m_acc);
      b = $signed(old_br);
      m_dbz = 0;
      m_done = 1;
      case (op_code)
        4'd1:  m_acc = '0;
        4'd2:  m_acc = arith(a + b);
        4'd3:  m_acc = arith(a - b);
        4'd4: begin
          p = longint'(a) * longint'(b);
          p_acc = p[15:0]; p_hi = p[31:16];
          m_busy = W + 1; m_done = 0;
        end
        4'd5: begin
          if (b == 0) begin
            m_hi = m_acc; m_acc = 16'hFFFF; m_dbz = 1;
          end else begin
            p_acc = 16'(a / b); p_hi = 16'(a % b);
            m_busy = W + 1; m_done = 0;
          end
        end
        4'd6, 4'd8: m_acc = m_acc << 1;
        4'd7:  m_acc = m_acc >> 1;
        4'd9:  m_acc = 16'(a >>> 1);
        4'd10: m_acc = m_acc & old_br;
        4'd11: m_acc = m_acc | old_br;
        4'd12: m_acc = ~m_acc;
        4'd13: m_acc = m_acc ^ old_br;
        4'd14: m_acc = ~(m_acc ^ old_br);
        default: ;
      endcase
    end
  endtask

  // Model advances at each rising edge; DUT compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (mon_en) begin
        check("mon_acc",   low_output,  m_acc);
        check("mon_hi",    high_output, m_hi);
        check("mon_flag",  flag,        m_acc[15]);
        check("mon_ready", op_ready,    (m_busy == 0));
        check("mon_done",  done,        m_done);
        check("mon_dbz",   div_by_zero, m_dbz);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_br(input logic [15:0] v);
    br_in = v;
    br_load = 1'b1;
    @(posedge clk); #2;
    br_load = 1'b0;
  endtask

  task automatic issue(input logic [3:0] code);
    bit rdy;
    op_code = code;
    op_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rdy = op_ready;
      @(posedge clk); #2;
      if (rdy) begin
        op_valid = 1'b0;
        $display("op %0d accepted: acc=0x%h br=0x%h", code, m_acc, m_br);
        return;
      end
    end
    op_valid = 1'b0;
    check("issue_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_acc(input logic [15:0] v);
    load_br(v);
    issue(4'd1);
    issue(4'd2);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [15:0] sat_add_exp, sat_sub_exp;
  logic [3:0]  logic_ops [5] = '{4'd10, 4'd11, 4'd13, 4'd14, 4'd12};
  logic [15:0] logic_exp [5] = '{16'h0C0C, 16'h0F0F, 16'h0000, 16'hF0F0, 16'h0F0F};
  logic [15:0] specials  [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0002};

  initial begin
    int bad_win;
    @(posedge clk); #2;
    mon_en = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_acc", low_output, 16'h0000);
    check("reset_ready", op_ready, 1'b1);
    check("reset_done", done, 1'b0);

    // ADD/SUB with BR=5
    load_br(16'd5);
    issue(4'd2);
    @(negedge clk);
    check("add_done_c1", done, 1'b1);
    issue(4'd2);
    issue(4'd3);
    @(negedge clk);
    check("addsub_acc", low_output, 16'd5);
    check("addsub_hi", high_output, 16'd0);
    check("model_addsub", m_acc, 16'd5);

    // MUL -3 * 7 with exact latency
    set_acc(16'hFFFD);
    load_br(16'd7);
    issue(4'd4);
    bad_win = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (op_ready !== 1'b0 || done !== 1'b0) bad_win++;
    end
    check("mul_busy_window", bad_win, 0);
    @(negedge clk);
    check("mul_done_c18", done, 1'b1);
    check("mul_lo", low_output, 16'hFFEB);
    check("mul_hi", high_output, 16'hFFFF);
    check("model_mul_lo", m_acc, 16'hFFEB);

    set_acc(16'h7FFF);
    issue(4'd4);
    wait_done("mul_max_done");
    check("mul_max_hi", high_output, 16'h3FFF);
    check("mul_max_lo", low_output, 16'h0001);

    // DIV -7 / 2, then divide by zero
    issue(4'd1);
    load_br(16'd7);
    issue(4'd3);
    load_br(16'd2);
    issue(4'd5);
    wait_done("div_done");
    check("div_quo", low_output, 16'hFFFD);
    check("div_rem", high_output, 16'hFFFF);
    check("model_div_rem", m_hi, 16'hFFFF);
    load_br(16'd0);
    issue(4'd5);
    @(negedge clk);
    check("dz_done_c1", done, 1'b1);
    check("dz_acc", low_output, 16'hFFFF);
    check("dz_hi", high_output, 16'hFFFD);
    check("dz_flag", div_by_zero, 1'b1);
    @(negedge clk);
    check("dz_hold", div_by_zero, 1'b1);
    issue(4'd0);
    @(negedge clk);
    check("dz_clear", div_by_zero, 1'b0);

    // MIN / -1
    set_acc(16'h8000);
    load_br(16'hFFFF);
    issue(4'd5);
    wait_done("div_min_done");
    check("div_min_quo", low_output, 16'h8000);
    check("div_min_rem", high_output, 16'h0000);

    // Shifts and logic
    set_acc(16'h8001);
    check("flag_set", flag, 1'b1);
    issue(4'd7);
    @(negedge clk);
    check("shr", low_output, 16'h4000);
    check("flag_clr", flag, 1'b0);
    set_acc(16'h8001);
    issue(4'd9);
    @(negedge clk);
    check("sar", low_output, 16'hC000);
    set_acc(16'h8001);
    issue(4'd6);
    @(negedge clk);
    check("shl", low_output, 16'h0002);
    set_acc(16'h3C3C);
    load_br(16'h0F0F);
    for (int k = 0; k < 5; k++) begin
      issue(logic_ops[k]);
      @(negedge clk);
      check($sformatf("logic_op%0d", logic_ops[k]), low_output, logic_exp[k]);
    end

    // op_valid held through MUL, BR reloaded mid-op, follow-on ADD in the done cycle
    set_acc(16'd3);
    load_br(16'd5);
    issue(4'd4);
    op_valid = 1'b1;
    op_code = 4'd2;
    repeat (4) begin @(posedge clk); #2; end
    load_br(16'h1234);
    wait_done("hold_mul_done");
    check("hold_mul_lo", low_output, 16'd15);
    check("hold_mul_hi", high_output, 16'd0);
    @(posedge clk); #2;
    op_valid = 1'b0;
    @(negedge clk);
    check("b2b_done", done, 1'b1);
    check("b2b_acc", low_output, 16'h1243);

    // Reset during RUN aborts without done
    set_acc(16'd3);
    load_br(16'd5);
    issue(4'd4);
    repeat (4) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_acc", low_output, 16'd0);
    check("abort_ready", op_ready, 1'b1);
    bad_win = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done !== 1'b0) bad_win++;
    end
    check("abort_no_done", bad_win, 0);

    // Overflow behaviour
`ifdef SEQ_ALU_SATURATE_EN
    sat_add_exp = 16'h7FFF;
    sat_sub_exp = 16'h8000;
`else
    sat_add_exp = 16'h8000;
    sat_sub_exp = 16'h7FFF;
`endif
    set_acc(16'h7FFF);
    load_br(16'd1);
    issue(4'd2);
    @(negedge clk);
    check("ovf_add", low_output, sat_add_exp);
    set_acc(16'h8000);
    load_br(16'd1);
    issue(4'd3);
    @(negedge clk);
    check("ovf_sub", low_output, sat_sub_exp);

    // Random traffic, checked by the per-cycle model compare
    @(posedge clk); #2;
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 249) == 0);
      op_valid = ($urandom_range(0, 3) != 0);
      op_code  = 4'($urandom_range(0, 15));
      br_load  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) br_in = specials[$urandom_range(0, 5)];
      else br_in = 16'($urandom);
      @(posedge clk); #2;
    end
    rst = 1'b0;
    op_valid = 1'b0;
    br_load = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
